// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
//   FIFO of fetched instruction words between MDR return and decode. Lets
//   fetch run ahead of execute by up to DEPTH words. The head entry is shown
//   on the outputs together with its pre-decoded operand-2 fields: the imm5
//   mode bit and the sign-extended imm5 value.
//
//   Optional build macro: IQ_OVERFLOW_FLAG_EN
//     defined     -> overflow is a sticky flag. It is set by a push attempt
//                    while the queue is full, and cleared by flush or reset.
//     not defined -> overflow is tied to 0 and no flag logic is built.
// -----------------------------------------------------------------------------
module instruction_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] instruction,
    output logic             imm_mode,
    output logic [WIDTH-1:0] imm5_sext,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    // Pointers wrap naturally because DEPTH is a power of two.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Sign-extends the 5-bit immediate field to the full word width.
    function automatic logic [WIDTH-1:0] sext_imm5(input logic [4:0] imm);
        return {{(WIDTH - 5){imm[4]}}, imm};
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] head_s;

    // Queue status and handshake qualification. Flush wins over push and pop.
    always_comb begin
        empty_s  = (count_q == {CNT_W{1'b0}});
        in_ready = (count_q < DEPTH_C);
        push_s   = in_valid && in_ready && !flush;
        pop_s    = out_ready && !empty_s && !flush;
    end

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage. Contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Head presentation. Every field reads as zero while the queue is empty.
    always_comb begin
        out_valid   = !empty_s;
        count       = count_q;
        head_s      = mem_q[rd_ptr_q];
        if (empty_s) begin
            instruction = {WIDTH{1'b0}};
            imm_mode    = 1'b0;
            imm5_sext   = {WIDTH{1'b0}};
        end else begin
            instruction = head_s;
            imm_mode    = head_s[5];
            imm5_sext   = sext_imm5(head_s[4:0]);
        end
    end

`ifdef IQ_OVERFLOW_FLAG_EN
    logic overflow_q;
    logic overflow_d;

    // Sticky overflow: set by a push attempt while full, cleared by flush.
    always_comb begin
        overflow_d = overflow_q;
        if (flush) begin
            overflow_d = 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_queue.sv
module tb_instruction_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] instruction;
    logic             imm_mode;
    logic [WIDTH-1:0] imm5_sext;
    logic [CNT_W-1:0] count;
    logic             overflow;

    instruction_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .instruction(instruction),
        .imm_mode   (imm_mode),
        .imm5_sext  (imm5_sext),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of words plus the sticky flag.
    logic [WIDTH-1:0] model_q[$];
    logic             model_ovf;

`ifdef IQ_OVERFLOW_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] head;
        int unsigned      imm;
        int unsigned      sx;
        head = (model_q.size() > 0) ? model_q[0] : 16'h0000;
        imm  = head % 32;
        sx   = (imm >= 16) ? (imm + 32'h0000_FFE0) : imm;
        check({tag, ".count"}, 32'(count), 32'(model_q.size()));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() > 0));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() < DEPTH));
        check({tag, ".instr"}, 32'(instruction), 32'(head));
        check({tag, ".imm_mode"}, 32'(imm_mode), 32'((head / 32) % 2));
        check({tag, ".imm5"}, 32'(imm5_sext), sx);
        check({tag, ".ovf"}, 32'(overflow), 32'(model_ovf));
    endtask

    // One clock: drive, update model on the edge, check 1 ns later.
    task automatic step(input logic v, input logic [WIDTH-1:0] d,
                        input logic rdy, input logic fl, input string tag);
        bit full;
        bit nonempty;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        full     = (model_q.size() == DEPTH);
        nonempty = (model_q.size() > 0);
        if (fl) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (v && full && OVF_EN) model_ovf = 1'b1;
            if (rdy && nonempty) void'(model_q.pop_front());
            if (v && !full) model_q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        model_ovf = 1'b0;
        #10;
        reset_n = 1'b1;
        #1;
        check_all("reset");
        check("reset.instr_const", 32'(instruction), 32'h0000_0000);
        check("reset.in_ready_const", 32'(in_ready), 32'h0000_0001);

        // Single push/pop
        step(1'b1, 16'h1029, 1'b0, 1'b0, "push1029");
        check("p1029.instr", 32'(instruction), 32'h0000_1029);
        check("p1029.mode", 32'(imm_mode), 32'h0000_0001);
        check("p1029.imm5", 32'(imm5_sext), 32'h0000_0009);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "pop1029");
        check("pop1029.count", 32'(count), 32'h0000_0000);
        check("pop1029.instr", 32'(instruction), 32'h0000_0000);

        // Sign extension
        step(1'b1, 16'h1039, 1'b0, 1'b0, "push1039");
        check("p1039.imm5", 32'(imm5_sext), 32'h0000_FFF9);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "pop1039");
        step(1'b1, 16'h1019, 1'b0, 1'b0, "push1019");
        check("p1019.mode", 32'(imm_mode), 32'h0000_0000);
        check("p1019.imm5", 32'(imm5_sext), 32'h0000_FFF9);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "pop1019");
        step(1'b1, 16'h102F, 1'b0, 1'b0, "push102F");
        check("p102F.imm5", 32'(imm5_sext), 32'h0000_000F);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "pop102F");

        // Fill and wrap
        step(1'b1, 16'd100, 1'b0, 1'b0, "fill0");
        step(1'b1, 16'd984, 1'b0, 1'b0, "fill1");
        step(1'b1, 16'd54, 1'b0, 1'b0, "fill2");
        step(1'b1, 16'd50, 1'b0, 1'b0, "fill3");
        check("full.count", 32'(count), 32'd4);
        check("full.in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 16'd7, 1'b0, 1'b0, "push_full");
        check("full.ovf", 32'(overflow), 32'(OVF_EN));
        check("full.count_kept", 32'(count), 32'd4);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "popA");
        step(1'b0, 16'h0000, 1'b1, 1'b0, "popB");
        step(1'b1, 16'd1, 1'b0, 1'b0, "wrap1");
        step(1'b1, 16'd2, 1'b0, 1'b0, "wrap2");
        check("wrap.head54", 32'(instruction), 32'd54);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "popC");
        check("wrap.head50", 32'(instruction), 32'd50);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "popD");
        check("wrap.head1", 32'(instruction), 32'd1);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "popE");
        check("wrap.head2", 32'(instruction), 32'd2);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "popF");
        check("wrap.empty", 32'(out_valid), 32'd0);

        // Simultaneous push/pop at count 2, then flush
        step(1'b1, 16'h0010, 1'b0, 1'b0, "sp0");
        step(1'b1, 16'h0020, 1'b0, 1'b0, "sp1");
        step(1'b1, 16'h0030, 1'b1, 1'b0, "sp_both");
        check("sp.count", 32'(count), 32'd2);
        check("sp.head", 32'(instruction), 32'h0000_0020);
        step(1'b1, 16'hABCD, 1'b1, 1'b1, "flush");
        check("flush.count", 32'(count), 32'd0);
        check("flush.valid", 32'(out_valid), 32'd0);
        check("flush.ovf", 32'(overflow), 32'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, "post_flush");
        check("flush.no_abcd", 32'(instruction), 32'h0000_0000);

        // Asynchronous reset mid-stream
        step(1'b1, 16'h0A0A, 1'b0, 1'b0, "ar0");
        step(1'b1, 16'h0B0B, 1'b0, 1'b0, "ar1");
        step(1'b1, 16'h0C0C, 1'b0, 1'b0, "ar2");
        check("ar.count3", 32'(count), 32'd3);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        check_all("async_rst");
        check("ar.count0", 32'(count), 32'd0);
        #2;
        reset_n = 1'b1;
        step(1'b1, 16'h0001, 1'b0, 1'b0, "ar_push");
        check("ar.alone_count", 32'(count), 32'd1);
        check("ar.alone_instr", 32'(instruction), 32'h0000_0001);
        step(1'b0, 16'h0000, 1'b1, 1'b0, "ar_pop");
        check("ar.alone_empty", 32'(out_valid), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 2) == 0 ? 0 : 1),
                 1'($urandom_range(0, 24) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
